ram_bist_master: RTL

RAM_BIST_MASTER -- requirements
Module: ram_bist_master

---
 rtl/ram_bist_master.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ram_bist_master.sv
// Memory BIST master: writes a selectable data pattern to a 256-entry RAM, reads it back,
// and reports the mismatch count, the first failing address and a pass/fail flag.
module ram_bist_master (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] pattern,
   output logic [7:0] ram_data_in,
   output logic       ram_write_enable,
   output logic       ram_read_enable,
   output logic [7:0] ram_address,
   input  logic [7:0] ram_data_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [8:0] err_count,
   output logic [7:0] fail_addr
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   state_t     state_reg, state_next;
   logic [1:0] pattern_reg, pattern_next;
   logic       cmp_valid_reg, cmp_valid_next;
   logic [7:0] cmp_addr_reg, cmp_addr_next;

   logic [7:0] data_next, addr_next, fail_next;
   logic       we_next, re_next, busy_next, done_next, pass_next;
   logic [8:0] err_next;
   logic       mismatch;

   function automatic logic [7:0] exp_data(input logic [1:0] p, input logic [7:0] a);
      case (p)
         2'b00:   exp_data = a;
         2'b01:   exp_data = ~a;
         2'b10:   exp_data = a[0] ? 8'hAA : 8'h55;
         default: exp_data = 8'hFF;
      endcase
   endfunction

   always_comb begin
      state_next     = state_reg;
      pattern_next   = pattern_reg;
      addr_next      = ram_address;
      data_next      = 8'h00;
      we_next        = 1'b0;
      re_next        = 1'b0;
      done_next      = 1'b0;
      pass_next      = pass;
      err_next       = err_count;
      fail_next      = fail_addr;
      // The RAM returns read data one cycle after the address, so compare one edge later.
      cmp_valid_next = ram_read_enable;
      cmp_addr_next  = ram_address;

      mismatch = cmp_valid_reg && (ram_data_out != exp_data(pattern_reg, cmp_addr_reg));
      if (mismatch) begin
         err_next = err_count + 9'd1;
         if (err_count == 9'd0)
            fail_next = cmp_addr_reg;
      end

      case (state_reg)
         IDLE: begin
            // The cycle showing done is treated as part of completion, so start is ignored then.
            if (start && !abort && !done) begin
               state_next   = WRITE;
               pattern_next = pattern;
               addr_next    = 8'h00;
               data_next    = exp_data(pattern, 8'h00);
               we_next      = 1'b1;
               err_next     = 9'd0;
               fail_next    = 8'h00;
               pass_next    = 1'b0;
            end
         end
         WRITE: begin
            if (ram_address == 8'hFF) begin
               state_next = READ;
               addr_next  = 8'h00;
               re_next    = 1'b1;
            end else begin
               addr_next = ram_address + 8'd1;
               data_next = exp_data(pattern_reg, ram_address + 8'd1);
               we_next   = 1'b1;
            end
         end
         READ: begin
            if (ram_address == 8'hFF) begin
               state_next = DRAIN;
               addr_next  = 8'h00;
            end else begin
               addr_next = ram_address + 8'd1;
               re_next   = 1'b1;
            end
         end
         DRAIN: state_next = DONE;
         DONE: begin
            state_next = IDLE;
            done_next  = 1'b1;
            pass_next  = (err_count == 9'd0);
         end
         default: state_next = IDLE;
      endcase

      if (abort && (state_reg == WRITE || state_reg == READ || state_reg == DRAIN)) begin
         state_next     = IDLE;
         addr_next      = 8'h00;
         data_next      = 8'h00;
         we_next        = 1'b0;
         re_next        = 1'b0;
         done_next      = 1'b0;
         pass_next      = 1'b0;
         err_next       = err_count;
         fail_next      = fail_addr;
         cmp_valid_next = 1'b0;
      end

      busy_next = (state_next == WRITE) || (state_next == READ) || (state_next == DRAIN);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         pattern_reg      <= 2'b00;
         cmp_valid_reg    <= 1'b0;
         cmp_addr_reg     <= 8'h00;
         ram_data_in      <= 8'h00;
         ram_write_enable <= 1'b0;
         ram_read_enable  <= 1'b0;
         ram_address      <= 8'h00;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= 9'd0;
         fail_addr        <= 8'h00;
      end else begin
         state_reg        <= state_next;
         pattern_reg      <= pattern_next;
         cmp_valid_reg    <= cmp_valid_next;
         cmp_addr_reg     <= cmp_addr_next;
         ram_data_in      <= data_next;
         ram_write_enable <= we_next;
         ram_read_enable  <= re_next;
         ram_address      <= addr_next;
         busy             <= busy_next;
         done             <= done_next;
         pass             <= pass_next;
         err_count        <= err_next;
         fail_addr        <= fail_next;
      end
   end

endmodule
